// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// PC source select, exception cause and ALU operation codes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    ST_LOAD   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_EXC    = 3'd6
  } state_t;

  localparam logic [2:0] PC_SRC_SEQ    = 3'd0;
  localparam logic [2:0] PC_SRC_BRANCH = 3'd1;
  localparam logic [2:0] PC_SRC_JUMP   = 3'd2;
  localparam logic [2:0] PC_SRC_EXC    = 3'd3;
  localparam logic [2:0] PC_SRC_LOAD   = 3'd4;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_OVF     = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_outdec.sv
// Combinational decode of FSM state + opcode into datapath control strobes.
// Zero latency; no handshake, outputs follow state within the same cycle.
module ctrl_outdec
  import mips_pkg::*;
(
  input  logic [2:0] state,
  input  logic [5:0] opcode,
  input  logic       sys_load,
  input  logic       alu_zero,
  output logic       pc_write,
  output logic [2:0] pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       mem_read,
  output logic       mem_write,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       epc_write
);

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    epc_write  = 1'b0;

    case (state_t'(state))
      ST_LOAD: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_LOAD;
      end
      ST_FETCH: begin
        // A preload request pre-empts the fetch entirely: PC and IR stay put.
        if (!sys_load) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          pc_src   = PC_SRC_SEQ;
        end
      end
      ST_EXEC: begin
        case (opcode)
          OP_RTYPE: alu_op = ALU_FUNCT;
          OP_LW, OP_SW, OP_ADDI: begin
            alu_src = 1'b1;
            alu_op  = ALU_ADD;
          end
          OP_BEQ: begin
            alu_op   = ALU_SUB;
            pc_src   = PC_SRC_BRANCH;
            pc_write = alu_zero;
          end
          OP_J: begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        alu_src   = 1'b1;
        mem_read  = (opcode == OP_LW);
        mem_write = (opcode == OP_SW);
      end
      ST_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (opcode == OP_RTYPE);
        mem_to_reg = (opcode == OP_LW);
      end
      ST_EXC: begin
        epc_write = 1'b1;
        pc_write  = 1'b1;
        pc_src    = PC_SRC_EXC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with
// fixed MEM_LAT DMEM wait states, exception capture and a retired counter.
module multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 16
) (
  input  logic             SYS_clk,
  input  logic             SYS_reset,
  input  logic             SYS_load,
  input  logic [5:0]       CTRL_opcode,
  input  logic             CTRL_alu_zero,
  input  logic             CTRL_alu_ovf,
  output logic             CTRL_pc_write,
  output logic [2:0]       CTRL_pc_src,
  output logic             CTRL_ir_write,
  output logic             CTRL_reg_write,
  output logic             CTRL_reg_dst,
  output logic             CTRL_mem_to_reg,
  output logic             CTRL_mem_read,
  output logic             CTRL_mem_write,
  output logic             CTRL_alu_src,
  output logic [1:0]       CTRL_alu_op,
  output logic             CTRL_epc_write,
  output logic [1:0]       CTRL_cause,
  output logic [2:0]       CTRL_state,
  output logic [CNT_W-1:0] CTRL_retired
);

  localparam logic [3:0] MEM_LAST = 4'(MEM_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       mem_cnt_q;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] retired_q;
  logic             mem_last;
  logic             retire;

  assign mem_last = (state_q == ST_MEM) && (mem_cnt_q == MEM_LAST);

  // State register plus the wait and retire counters; reset overrides all.
  always_ff @(posedge SYS_clk) begin
    if (SYS_reset) begin
      state_q   <= ST_FETCH;
      mem_cnt_q <= 4'd0;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if ((state_q == ST_MEM) && !mem_last) begin
        mem_cnt_q <= mem_cnt_q + 4'd1;
      end else begin
        mem_cnt_q <= 4'd0;
      end
      if (retire) begin
        retired_q <= retired_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    retire  = 1'b0;

    case (state_q)
      ST_LOAD:   state_d = SYS_load ? ST_LOAD : ST_FETCH;
      ST_FETCH:  state_d = SYS_load ? ST_LOAD : ST_DECODE;
      ST_DECODE: begin
        if (op_legal(CTRL_opcode)) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_EXC;
          cause_d = CAUSE_ILLEGAL;
        end
      end
      ST_EXEC: begin
        case (CTRL_opcode)
          OP_RTYPE, OP_ADDI: begin
            // Overflow diverts to EXC so write-back never happens.
            if (CTRL_alu_ovf) begin
              state_d = ST_EXC;
              cause_d = CAUSE_OVF;
            end else begin
              state_d = ST_WB;
            end
          end
          OP_LW, OP_SW: state_d = ST_MEM;
          OP_BEQ, OP_J: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (mem_last) begin
          if (CTRL_opcode == OP_LW) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_FETCH;
            retire  = (CTRL_opcode == OP_SW);
          end
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_EXC:  state_d = ST_FETCH;
      default: state_d = ST_FETCH;
    endcase
  end

  ctrl_outdec u_outdec (
    .state      (state_q),
    .opcode     (CTRL_opcode),
    .sys_load   (SYS_load),
    .alu_zero   (CTRL_alu_zero),
    .pc_write   (CTRL_pc_write),
    .pc_src     (CTRL_pc_src),
    .ir_write   (CTRL_ir_write),
    .reg_write  (CTRL_reg_write),
    .reg_dst    (CTRL_reg_dst),
    .mem_to_reg (CTRL_mem_to_reg),
    .mem_read   (CTRL_mem_read),
    .mem_write  (CTRL_mem_write),
    .alu_src    (CTRL_alu_src),
    .alu_op     (CTRL_alu_op),
    .epc_write  (CTRL_epc_write)
  );

  assign CTRL_cause   = cause_q;
  assign CTRL_state   = state_q;
  assign CTRL_retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed per-cycle vectors for multicycle_ctrl (MEM_LAT=2), plus a narrow
// counter instance sharing the same stimulus to exercise retired wrap-around.
module tb_multicycle_ctrl;

  logic        SYS_clk = 1'b0;
  logic        SYS_reset;
  logic        SYS_load;
  logic [5:0]  CTRL_opcode;
  logic        CTRL_alu_zero;
  logic        CTRL_alu_ovf;
  logic        CTRL_pc_write, CTRL_ir_write, CTRL_reg_write, CTRL_reg_dst;
  logic        CTRL_mem_to_reg, CTRL_mem_read, CTRL_mem_write, CTRL_alu_src;
  logic        CTRL_epc_write;
  logic [2:0]  CTRL_pc_src, CTRL_state;
  logic [1:0]  CTRL_alu_op, CTRL_cause;
  logic [15:0] CTRL_retired;

  logic        s_pc_write, s_ir_write, s_reg_write, s_reg_dst;
  logic        s_mem_to_reg, s_mem_read, s_mem_write, s_alu_src, s_epc_write;
  logic [2:0]  s_pc_src, s_state;
  logic [1:0]  s_alu_op, s_cause;
  logic [3:0]  s_retired;

  int checks = 0;
  int errors = 0;
  bit mon_on = 1'b0;

  always #5 SYS_clk = ~SYS_clk;

  multicycle_ctrl #(.MEM_LAT(2), .CNT_W(16)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .SYS_load(SYS_load),
    .CTRL_opcode(CTRL_opcode), .CTRL_alu_zero(CTRL_alu_zero), .CTRL_alu_ovf(CTRL_alu_ovf),
    .CTRL_pc_write(CTRL_pc_write), .CTRL_pc_src(CTRL_pc_src), .CTRL_ir_write(CTRL_ir_write),
    .CTRL_reg_write(CTRL_reg_write), .CTRL_reg_dst(CTRL_reg_dst),
    .CTRL_mem_to_reg(CTRL_mem_to_reg), .CTRL_mem_read(CTRL_mem_read),
    .CTRL_mem_write(CTRL_mem_write), .CTRL_alu_src(CTRL_alu_src), .CTRL_alu_op(CTRL_alu_op),
    .CTRL_epc_write(CTRL_epc_write), .CTRL_cause(CTRL_cause), .CTRL_state(CTRL_state),
    .CTRL_retired(CTRL_retired)
  );

  multicycle_ctrl #(.MEM_LAT(2), .CNT_W(4)) dut_small (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset), .SYS_load(SYS_load),
    .CTRL_opcode(CTRL_opcode), .CTRL_alu_zero(CTRL_alu_zero), .CTRL_alu_ovf(CTRL_alu_ovf),
    .CTRL_pc_write(s_pc_write), .CTRL_pc_src(s_pc_src), .CTRL_ir_write(s_ir_write),
    .CTRL_reg_write(s_reg_write), .CTRL_reg_dst(s_reg_dst),
    .CTRL_mem_to_reg(s_mem_to_reg), .CTRL_mem_read(s_mem_read),
    .CTRL_mem_write(s_mem_write), .CTRL_alu_src(s_alu_src), .CTRL_alu_op(s_alu_op),
    .CTRL_epc_write(s_epc_write), .CTRL_cause(s_cause), .CTRL_state(s_state),
    .CTRL_retired(s_retired)
  );

  typedef struct packed {
    logic [2:0]  st;
    logic        pcw;
    logic [2:0]  pcs;
    logic        irw, rw, rdst, m2r, mrd, mwr, asrc;
    logic [1:0]  aop;
    logic        epc;
    logic [1:0]  cause;
    logic [15:0] ret;
  } out_t;

  typedef struct {
    string      name;
    logic       rst, load;
    logic [5:0] op;
    logic       z, ovf;
    out_t       exp;
  } vec_t;

  vec_t tbl[$];

  function automatic out_t o(int st, int pcw, int pcs, int irw, int rw, int rdst, int m2r,
                             int mrd, int mwr, int asrc, int aop, int epc, int cause, int ret);
    out_t r;
    r.st = 3'(st); r.pcw = 1'(pcw); r.pcs = 3'(pcs); r.irw = 1'(irw); r.rw = 1'(rw);
    r.rdst = 1'(rdst); r.m2r = 1'(m2r); r.mrd = 1'(mrd); r.mwr = 1'(mwr);
    r.asrc = 1'(asrc); r.aop = 2'(aop); r.epc = 1'(epc); r.cause = 2'(cause);
    r.ret = 16'(ret);
    return r;
  endfunction

  task automatic v(string n, int rst, int load, int op, int z, int ovf, out_t e);
    vec_t x;
    x.name = n; x.rst = 1'(rst); x.load = 1'(load); x.op = 6'(op);
    x.z = 1'(z); x.ovf = 1'(ovf); x.exp = e;
    tbl.push_back(x);
  endtask

  task automatic check(string n, out_t e);
    out_t a;
    a = {CTRL_state, CTRL_pc_write, CTRL_pc_src, CTRL_ir_write, CTRL_reg_write,
         CTRL_reg_dst, CTRL_mem_to_reg, CTRL_mem_read, CTRL_mem_write, CTRL_alu_src,
         CTRL_alu_op, CTRL_epc_write, CTRL_cause, CTRL_retired};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic check_val(string n, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, got, want);
    end
  endtask

  // Invariant: DMEM read and write strobes are mutually exclusive.
  always @(negedge SYS_clk) begin
    if (mon_on) begin
      checks++;
      if (CTRL_mem_read && CTRL_mem_write) begin
        errors++;
        $display("FAIL mem_rw_exclusive got rd=%b wr=%b want not both", CTRL_mem_read,
                 CTRL_mem_write);
      end
    end
  end

  initial begin
    //   name      rst ld op    z ovf   st pcw pcs irw rw rd m2r mr mw as aop epc c  ret
    v("add_F",    0, 0, 'h00, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v("add_D",    0, 0, 'h00, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    v("add_E",    0, 0, 'h00, 0, 0, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    v("add_W",    0, 0, 'h00, 0, 0, o(5, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    v("lw_F",     0, 0, 'h23, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v("lw_D",     0, 0, 'h23, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    v("lw_E",     0, 0, 'h23, 0, 0, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    v("lw_M0",    0, 0, 'h23, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    v("lw_M1",    0, 0, 'h23, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    v("lw_W",     0, 0, 'h23, 0, 0, o(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    v("sw_F",     0, 0, 'h2B, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    v("sw_D",     0, 0, 'h2B, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
    v("sw_E",     0, 0, 'h2B, 0, 0, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2));
    v("sw_M0",    0, 0, 'h2B, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2));
    v("sw_M1",    0, 0, 'h2B, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 2));
    v("beq0_F",   0, 0, 'h04, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    v("beq0_D",   0, 0, 'h04, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    v("beq0_E",   0, 0, 'h04, 0, 0, o(3, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 3));
    v("beq1_F",   0, 0, 'h04, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    v("beq1_D",   0, 0, 'h04, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4));
    v("beq1_E",   0, 0, 'h04, 1, 0, o(3, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4));
    v("ill_F",    0, 0, 'h3F, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    v("ill_D",    0, 0, 'h3F, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5));
    v("ill_X",    0, 0, 'h3F, 0, 0, o(6, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5));
    v("ovf_F",    0, 0, 'h08, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
    v("ovf_D",    0, 0, 'h08, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
    v("ovf_E",    0, 0, 'h08, 0, 1, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 5));
    v("ovf_X",    0, 0, 'h08, 0, 0, o(6, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 5));
    v("j_F",      0, 0, 'h02, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 5));
    v("j_D",      0, 0, 'h02, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 5));
    v("j_E",      0, 0, 'h02, 0, 0, o(3, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 5));
    v("ld_F",     0, 1, 'h02, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 6));
    v("ld_L0",    0, 1, 'h02, 0, 0, o(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 6));
    v("ld_L1",    0, 1, 'h02, 0, 0, o(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 6));
    v("ld_L2",    0, 0, 'h02, 0, 0, o(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 6));
    v("lwl_F",    0, 0, 'h23, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 6));
    v("lwl_D",    0, 0, 'h23, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 6));
    v("lwl_E",    0, 0, 'h23, 0, 0, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 6));
    v("lwl_M0",   0, 1, 'h23, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2, 6));
    v("lwl_M1",   0, 1, 'h23, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 2, 6));
    v("lwl_W",    0, 0, 'h23, 0, 0, o(5, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 2, 6));
    v("swr_F",    0, 0, 'h2B, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 7));
    v("swr_D",    0, 0, 'h2B, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 7));
    v("swr_E",    0, 0, 'h2B, 0, 0, o(3, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 7));
    v("swr_M0",   0, 0, 'h2B, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 7));
    v("swr_M1",   1, 0, 'h2B, 0, 0, o(4, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 2, 7));
    v("swr_after",0, 0, 'h2B, 0, 0, o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    SYS_reset = 1'b1; SYS_load = 1'b0; CTRL_opcode = 6'h00;
    CTRL_alu_zero = 1'b0; CTRL_alu_ovf = 1'b0;
    repeat (2) @(posedge SYS_clk);
    #1;
    mon_on = 1'b1;
    @(negedge SYS_clk);
    check("reset", o(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge SYS_clk);
    #1;

    foreach (tbl[i]) begin
      SYS_reset     = tbl[i].rst;
      SYS_load      = tbl[i].load;
      CTRL_opcode   = tbl[i].op;
      CTRL_alu_zero = tbl[i].z;
      CTRL_alu_ovf  = tbl[i].ovf;
      @(negedge SYS_clk);
      check(tbl[i].name, tbl[i].exp);
      @(posedge SYS_clk);
      #1;
    end

    // Wrap-around: 15 jumps fill the 4-bit counter, the 16th rolls it to 0.
    SYS_reset = 1'b1; SYS_load = 1'b0; CTRL_alu_zero = 1'b0; CTRL_alu_ovf = 1'b0;
    CTRL_opcode = 6'h02;
    @(posedge SYS_clk);
    #1;
    SYS_reset = 1'b0;
    @(negedge SYS_clk);
    check_val("small_reset", 32'(s_retired), 32'h0);
    @(posedge SYS_clk);
    #1;
    repeat (15 * 3 - 1) @(posedge SYS_clk);
    #1;
    @(negedge SYS_clk);
    check_val("small_full", 32'(s_retired), 32'hF);
    check_val("main_15", 32'(CTRL_retired), 32'd15);
    repeat (3) @(posedge SYS_clk);
    #1;
    @(negedge SYS_clk);
    check_val("small_wrap", 32'(s_retired), 32'h0);
    check_val("main_16", 32'(CTRL_retired), 32'd16);
    check_val("wrap_state", 32'(s_state), 32'd1);

    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
